// File: rtl/hex_disp_pkg.sv
// rtl/hex_disp_pkg.sv - shared constants and helpers for the hex display scan controller.
package hex_disp_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int IDX_W      = 3;

    localparam logic SRC_A = 1'b0;
    localparam logic SRC_B = 1'b1;

    typedef logic [IDX_W-1:0] digit_idx_t;

    // Index of the most significant nonzero nibble; 0 when the whole frame is zero.
    function automatic digit_idx_t msd_index(input logic [4*NUM_DIGITS-1:0] f);
        digit_idx_t msd;
        msd = '0;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (f[k*4 +: 4] != 4'd0) begin
                msd = digit_idx_t'(k);
            end
        end
        return msd;
    endfunction

endpackage

// File: rtl/scan_tick_gen.sv
// rtl/scan_tick_gen.sv - digit slot counter; flags the last cycle of a slot and the blanking window.
module scan_tick_gen #(
    parameter int DIV   = 1024,
    parameter int BLANK = 16
) (
    input  logic clk,
    input  logic rst,
    output logic tick,
    output logic in_blank
);

    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CNT_W-1:0] r_cnt;

    assign tick = (r_cnt == CNT_W'(DIV - 1));

    generate
        if (BLANK == 0) begin : g_no_blank
            assign in_blank = 1'b0;
        end else begin : g_blank
            assign in_blank = (r_cnt < CNT_W'(BLANK));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (tick) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/hex_scan_ctrl.sv
// rtl/hex_scan_ctrl.sv - round-robin frame arbiter and 8-digit scan sequencer.
// HEX_SCAN_LZB_EN enables leading-zero blanking of the displayed frame.
module hex_scan_ctrl
    import hex_disp_pkg::*;
#(
    parameter int DIV   = 1024,
    parameter int BLANK = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    a_valid,
    input  logic [4*NUM_DIGITS-1:0] a_data,
    output logic                    a_ready,
    input  logic                    b_valid,
    input  logic [4*NUM_DIGITS-1:0] b_data,
    output logic                    b_ready,
    output logic [NUM_DIGITS-1:0]   anodes,
    output logic [3:0]              nibble,
    output logic                    owner
);

    logic                    w_tick;
    logic                    w_in_blank;
    logic                    w_fb;
    logic                    w_suppress;
    logic [NUM_DIGITS-1:0]   w_onehot;

    digit_idx_t              r_idx;
    logic [4*NUM_DIGITS-1:0] r_frame;
    logic                    r_owner;
    logic                    r_rr;

    scan_tick_gen #(
        .DIV   (DIV),
        .BLANK (BLANK)
    ) u_tick (
        .clk      (clk),
        .rst      (rst),
        .tick     (w_tick),
        .in_blank (w_in_blank)
    );

    assign w_fb = w_tick && (r_idx == digit_idx_t'(NUM_DIGITS - 1));

    // rr only breaks ties; a lone requester is granted regardless of the pointer.
    assign a_ready = w_fb && a_valid && (!b_valid || (r_rr == SRC_A));
    assign b_ready = w_fb && b_valid && (!a_valid || (r_rr == SRC_B));

    always_ff @(posedge clk) begin
        if (rst) begin
            r_idx   <= '0;
            r_frame <= '0;
            r_owner <= SRC_A;
            r_rr    <= SRC_A;
        end else begin
            if (w_tick) begin
                r_idx <= r_idx + 1'b1;
            end
            if (a_ready) begin
                r_frame <= a_data;
                r_owner <= SRC_A;
                r_rr    <= SRC_B;
            end else if (b_ready) begin
                r_frame <= b_data;
                r_owner <= SRC_B;
                r_rr    <= SRC_A;
            end
        end
    end

`ifdef HEX_SCAN_LZB_EN
    assign w_suppress = (r_idx > msd_index(r_frame));
`else
    assign w_suppress = 1'b0;
`endif

    assign w_onehot = {{(NUM_DIGITS-1){1'b0}}, 1'b1} << r_idx;
    assign anodes   = (w_in_blank || w_suppress) ? '0 : w_onehot;
    assign nibble   = r_frame[{r_idx, 2'b00} +: 4];
    assign owner    = r_owner;

endmodule
